// File: rtl/ddr3_readback_checker.sv
// Checks the controller read-data stream against the incrementing pattern written by the
// traffic generator; reports mismatch count, first failure, watchdog timeout and pass/done.
module ddr3_readback_checker #(
   parameter int DQ_BITWIDTH           = 16,
   parameter int ADDRESS_BITWIDTH      = 15,
   parameter int BANK_ADDRESS_BITWIDTH = 3,
   parameter int NUM_WORDS             = 1024,
   parameter int TIMEOUT_CYCLES        = 4096,
   parameter int ERR_CNT_BITWIDTH      = 16,
   parameter logic [DQ_BITWIDTH-1:0] DATA_OFFSET = '0,
   localparam int IDX_W = ADDRESS_BITWIDTH + BANK_ADDRESS_BITWIDTH
) (
   input  logic                        clk,
   input  logic                        resetn,
   input  logic                        start,
   input  logic                        i_rd_valid,
   input  logic [DQ_BITWIDTH-1:0]      i_rd_data,
   output logic                        o_busy,
   output logic                        o_done,
   output logic                        o_pass,
   output logic                        o_timeout,
   output logic [ERR_CNT_BITWIDTH-1:0] o_error_count,
   output logic [IDX_W-1:0]            o_first_err_index,
   output logic [DQ_BITWIDTH-1:0]      o_first_err_data
);

   localparam int WD_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);
   localparam logic [WD_W-1:0]  WD_LIMIT = WD_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

   state_t                 state_reg;
   logic [IDX_W-1:0]       idx_reg;
   logic [WD_W-1:0]        wd_reg;
   logic                   s1_valid_reg;
   logic [DQ_BITWIDTH-1:0] s1_data_reg;
   logic [DQ_BITWIDTH-1:0] s1_exp_reg;
   logic [IDX_W-1:0]       s1_idx_reg;

   logic accept;
   logic mismatch;
   logic restart;

   assign accept   = (state_reg == RUN) && i_rd_valid;
   assign mismatch = s1_valid_reg && (s1_data_reg != s1_exp_reg);
   assign restart  = start && ((state_reg == IDLE) || (state_reg == DONE));

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_reg         <= IDLE;
         idx_reg           <= '0;
         wd_reg            <= '0;
         s1_valid_reg      <= 1'b0;
         s1_data_reg       <= '0;
         s1_exp_reg        <= '0;
         s1_idx_reg        <= '0;
         o_busy            <= 1'b0;
         o_done            <= 1'b0;
         o_pass            <= 1'b0;
         o_timeout         <= 1'b0;
         o_error_count     <= '0;
         o_first_err_index <= '0;
         o_first_err_data  <= '0;
      end else begin
         // Stage 1: capture the accepted word alongside its expected pattern value.
         s1_valid_reg <= accept;
         if (accept) begin
            s1_data_reg <= i_rd_data;
            s1_exp_reg  <= DQ_BITWIDTH'(idx_reg) + DATA_OFFSET;
            s1_idx_reg  <= idx_reg;
            idx_reg     <= idx_reg + 1'b1;
         end

         if (restart) begin
            state_reg         <= RUN;
            idx_reg           <= '0;
            wd_reg            <= '0;
            s1_valid_reg      <= 1'b0;
            o_busy            <= 1'b1;
            o_done            <= 1'b0;
            o_pass            <= 1'b0;
            o_timeout         <= 1'b0;
            o_error_count     <= '0;
            o_first_err_index <= '0;
            o_first_err_data  <= '0;
         end else begin
            // Stage 2: a zero count means no earlier error, since the counter saturates.
            if (mismatch) begin
               if (o_error_count == '0) begin
                  o_first_err_index <= s1_idx_reg;
                  o_first_err_data  <= s1_data_reg;
               end
               if (o_error_count != '1)
                  o_error_count <= o_error_count + 1'b1;
            end

            case (state_reg)
               RUN: begin
                  if (accept) begin
                     wd_reg <= '0;
                     if (idx_reg == LAST_IDX)
                        state_reg <= FLUSH;
                  end else if (wd_reg == WD_LIMIT) begin
                     state_reg <= DONE;
                     o_busy    <= 1'b0;
                     o_done    <= 1'b1;
                     o_timeout <= 1'b1;
                     o_pass    <= 1'b0;
                  end else begin
                     wd_reg <= wd_reg + 1'b1;
                  end
               end
               FLUSH: begin
                  // The final word's compare lands this edge, so fold it into the verdict.
                  state_reg <= DONE;
                  o_busy    <= 1'b0;
                  o_done    <= 1'b1;
                  o_pass    <= (o_error_count == '0) && !mismatch;
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_ddr3_readback_checker.sv
// Directed bench: four checker instances with different parameters, a per-cycle vector
// table for the basic pass/fail runs, and hand-written sequences for the multi-cycle cases.
module tb_ddr3_readback_checker;

   logic clk;
   logic resetn;
   logic [3:0] start_v;
   logic [3:0] vld_v;
   logic [15:0] dat_v [4];
   logic [3:0] busy_v;
   logic [3:0] done_v;
   logic [3:0] pass_v;
   logic [3:0] tmo_v;
   logic [15:0] ec_v [4];
   logic [17:0] fidx_v [4];
   logic [15:0] fdat_v [4];

   int total = 0;
   int bad = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Instance 0: NUM_WORDS=8; 1: NUM_WORDS=4, TIMEOUT=16; 2: 2-bit error counter; 3: offset 0xF0.
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_dut
         localparam int ECW = (gi == 2) ? 2 : 16;
         logic [ECW-1:0] ec_loc;
         ddr3_readback_checker #(
            .NUM_WORDS       ((gi == 1) ? 4 : 8),
            .TIMEOUT_CYCLES  ((gi == 1) ? 16 : 4096),
            .ERR_CNT_BITWIDTH(ECW),
            .DATA_OFFSET     ((gi == 3) ? 16'h00F0 : 16'h0000)
         ) u_dut (
            .clk              (clk),
            .resetn           (resetn),
            .start            (start_v[gi]),
            .i_rd_valid       (vld_v[gi]),
            .i_rd_data        (dat_v[gi]),
            .o_busy           (busy_v[gi]),
            .o_done           (done_v[gi]),
            .o_pass           (pass_v[gi]),
            .o_timeout        (tmo_v[gi]),
            .o_error_count    (ec_loc),
            .o_first_err_index(fidx_v[gi]),
            .o_first_err_data (fdat_v[gi])
         );
         assign ec_v[gi] = 16'(ec_loc);
      end
   endgenerate

   typedef struct {
      logic        st;
      logic        v;
      logic [15:0] d;
      logic        busy;
      logic        done;
      logic        pass;
      logic [15:0] ec;
   } vec_t;

   vec_t tbl[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // One clock of stimulus to instance d; outputs are sampled 1 ns after the edge.
   task automatic drive(input int d, input logic s, input logic v, input logic [15:0] w);
      start_v[d] = s;
      vld_v[d]   = v;
      dat_v[d]   = w;
      @(posedge clk);
      #1;
      start_v[d] = 1'b0;
      vld_v[d]   = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "bench time limit");
   end

   initial begin
      int n;
      logic [15:0] w;
      resetn  = 1'b1;
      start_v = '0;
      vld_v   = '0;
      for (int i = 0; i < 4; i++) dat_v[i] = '0;
      #2 resetn = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("reset_outs_%0d", i),
             {28'd0, busy_v[i], done_v[i], pass_v[i], tmo_v[i]}, 32'd0);
         chk($sformatf("reset_ec_%0d", i), {16'd0, ec_v[i]}, 32'd0);
      end
      resetn = 1'b1;
      drive(0, 0, 0, 0);

      // Runs 1 and 2 on instance 0: clean run, then word 5 corrupted.
      tbl.push_back('{1'b1, 1'b0, 16'h0, 1'b1, 1'b0, 1'b0, 16'd0});
      for (int k = 0; k < 8; k++)
         tbl.push_back('{1'b0, 1'b1, 16'(k), 1'b1, 1'b0, 1'b0, 16'd0});
      tbl.push_back('{1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 1'b1, 16'd0});
      tbl.push_back('{1'b1, 1'b0, 16'h0, 1'b1, 1'b0, 1'b0, 16'd0});
      for (int k = 0; k < 8; k++)
         tbl.push_back('{1'b0, 1'b1, (k == 5) ? 16'hFFFF : 16'(k), 1'b1, 1'b0, 1'b0,
                         (k >= 6) ? 16'd1 : 16'd0});
      tbl.push_back('{1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 1'b0, 16'd1});

      for (int r = 0; r < tbl.size(); r++) begin
         drive(0, tbl[r].st, tbl[r].v, tbl[r].d);
         chk($sformatf("tbl%0d_busy", r), {31'd0, busy_v[0]}, {31'd0, tbl[r].busy});
         chk($sformatf("tbl%0d_done", r), {31'd0, done_v[0]}, {31'd0, tbl[r].done});
         chk($sformatf("tbl%0d_pass", r), {31'd0, pass_v[0]}, {31'd0, tbl[r].pass});
         chk($sformatf("tbl%0d_ec", r), {16'd0, ec_v[0]}, {16'd0, tbl[r].ec});
      end
      chk("t2_first_idx", {14'd0, fidx_v[0]}, 32'd5);
      chk("t2_first_data", {16'd0, fdat_v[0]}, 32'h0000FFFF);

      // Run 3: two words then silence; watchdog must end the run 16 clocks after the last accept.
      drive(1, 1, 0, 0);
      drive(1, 0, 1, 16'd0);
      drive(1, 0, 1, 16'd1);
      chk("t3_busy_after_words", {31'd0, busy_v[1]}, 32'd1);
      n = 0;
      while (!done_v[1] && n < 40) begin
         drive(1, 0, 0, 0);
         n++;
      end
      chk("t3_timeout_latency", n, 32'd16);
      chk("t3_timeout", {31'd0, tmo_v[1]}, 32'd1);
      chk("t3_pass", {31'd0, pass_v[1]}, 32'd0);
      chk("t3_busy", {31'd0, busy_v[1]}, 32'd0);
      chk("t3_ec", {16'd0, ec_v[1]}, 32'd0);

      // Run 4: six of eight words bad on a 2-bit counter -> saturates at 3.
      drive(2, 1, 0, 0);
      for (int k = 0; k < 8; k++) begin
         w = 16'(k);
         if (k != 0 && k != 3) w = ~w;
         drive(2, 0, 1, w);
      end
      drive(2, 0, 0, 0);
      chk("t4_done", {31'd0, done_v[2]}, 32'd1);
      chk("t4_ec_sat", {16'd0, ec_v[2]}, 32'd3);
      chk("t4_first_idx", {14'd0, fidx_v[2]}, 32'd1);
      chk("t4_first_data", {16'd0, fdat_v[2]}, 32'h0000FFFE);
      chk("t4_pass", {31'd0, pass_v[2]}, 32'd0);

      // Run 5: start with a simultaneous valid (must not be taken), gapped words, trailing valids.
      drive(3, 1, 1, 16'h00F0);
      for (int k = 0; k < 8; k++) begin
         drive(3, 0, 1, 16'h00F0 + 16'(k));
         for (int g = 0; g < 3; g++) drive(3, 0, (k == 7), 16'hBEEF);
      end
      chk("t5_done", {31'd0, done_v[3]}, 32'd1);
      chk("t5_pass", {31'd0, pass_v[3]}, 32'd1);
      chk("t5_ec", {16'd0, ec_v[3]}, 32'd0);
      chk("t5_timeout", {31'd0, tmo_v[3]}, 32'd0);

      // Run 6: asynchronous reset in the middle of a run with an error already counted.
      drive(0, 1, 0, 0);
      drive(0, 0, 1, 16'd0);
      drive(0, 0, 1, 16'h0F0F);
      drive(0, 0, 1, 16'd2);
      chk("t6_pre_busy", {31'd0, busy_v[0]}, 32'd1);
      chk("t6_pre_ec", {16'd0, ec_v[0]}, 32'd1);
      vld_v[0] = 1'b1;
      dat_v[0] = 16'd3;
      #2 resetn = 1'b0;
      #1;
      chk("t6_rst_flags", {28'd0, busy_v[0], done_v[0], pass_v[0], tmo_v[0]}, 32'd0);
      chk("t6_rst_ec", {16'd0, ec_v[0]}, 32'd0);
      chk("t6_rst_fidx", {14'd0, fidx_v[0]}, 32'd0);
      chk("t6_rst_fdat", {16'd0, fdat_v[0]}, 32'd0);
      @(posedge clk);
      #1;
      vld_v[0] = 1'b0;
      resetn = 1'b1;
      drive(0, 0, 0, 0);
      drive(0, 1, 0, 0);
      for (int k = 0; k < 8; k++) drive(0, 0, 1, 16'(k));
      chk("t6_flush_not_done", {31'd0, done_v[0]}, 32'd0);
      drive(0, 0, 0, 0);
      chk("t6_done", {31'd0, done_v[0]}, 32'd1);
      chk("t6_pass", {31'd0, pass_v[0]}, 32'd1);
      chk("t6_ec", {16'd0, ec_v[0]}, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
